// File: rtl/reg_xfer_pkg.sv
// reg_xfer_pkg: shared FSM state type and register-index constants for the RF<->RM transfer engine
package reg_xfer_pkg;
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] FIRST_REG = 5'd1;
    localparam logic [IDX_W-1:0] LAST_REG  = 5'd31;
    typedef enum logic [2:0] {IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WR, FIN} xfer_state_t;
endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: registered one-cycle pulse on a rising edge of a level input
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (history cleared, so a level held through reset reads as an edge)
//   i_level : level input
//   o_pulse : one-cycle pulse, one cycle after the edge is sampled
module rise_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);
    logic r_prev;
    logic r_pulse;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end
    assign o_pulse = r_pulse;
endmodule

// File: rtl/reg_bank_transfer_unit.sv
// reg_bank_transfer_unit: sequences x1..x31 between the register file (RF) and banked register memory (RM)
//   i_clk, i_rst_n       : clock (rising edge), asynchronous active-low reset
//   i_start_save         : level request RF -> RM (rising edge detected)
//   i_start_restore      : level request RM -> RF (rising edge detected; loses to save in the same cycle)
//   i_bank_sel           : RM bank, latched at start
//   o_rf_addr/i_rf_rdata : RF index and combinational read data
//   o_rf_wdata/o_rf_we   : RF write data and one-cycle write enable
//   o_rm_addr            : {bank, index}
//   o_rm_wdata/o_rm_we   : RM write data and write request
//   i_rm_rdata/o_rm_re   : RM read data and read request
//   i_rm_busywait        : RM stall, a request completes on an edge where it is low
//   o_busy/o_done        : transfer in progress / one-cycle completion pulse
//   o_err/o_checksum     : sticky checksum mismatch / running XOR, present only with REG_XFER_CHECKSUM_EN
module reg_bank_transfer_unit
    import reg_xfer_pkg::*;
#(
    parameter  int BANKS = 4,
    localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int AW    = $clog2(BANKS) + 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start_save,
    input  logic          i_start_restore,
    input  logic [BW-1:0] i_bank_sel,
    output logic [4:0]    o_rf_addr,
    input  logic [31:0]   i_rf_rdata,
    output logic [31:0]   o_rf_wdata,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rm_addr,
    output logic [31:0]   o_rm_wdata,
    input  logic [31:0]   i_rm_rdata,
    output logic          o_rm_we,
    output logic          o_rm_re,
    input  logic          i_rm_busywait,
    output logic          o_busy,
    output logic          o_done
`ifdef REG_XFER_CHECKSUM_EN
    ,
    output logic          o_err,
    output logic [31:0]   o_checksum
`endif
);
    xfer_state_t r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [BW-1:0]    r_bank;
    logic [31:0]      r_rm_wdata, r_rf_wdata;
    logic w_save_go, w_rst_go, w_start, w_last, w_save_commit, w_rd_commit;
    logic [BW+IDX_W-1:0] w_rm_addr_full;

    rise_edge_det u_save_edge (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_level(i_start_save),    .o_pulse(w_save_go));
    rise_edge_det u_rst_edge  (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_level(i_start_restore), .o_pulse(w_rst_go));

    assign w_start        = (r_state == IDLE) && (w_save_go || w_rst_go);
    assign w_last         = (r_idx == LAST_REG);
    assign w_save_commit  = (r_state == SAVE_WR) && !i_rm_busywait;
    assign w_rd_commit    = (r_state == RST_RD) && !i_rm_busywait;
    assign w_rm_addr_full = {r_bank, r_idx};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        o_rf_addr = '0;
        o_rm_addr = '0;
        o_rf_we   = 1'b0;
        o_rm_we   = 1'b0;
        o_rm_re   = 1'b0;
        o_done    = 1'b0;
        o_busy    = (r_state != IDLE);
        case (r_state)
            IDLE:    w_next = w_save_go ? SAVE_RD : (w_rst_go ? RST_RD : IDLE);
            SAVE_RD: begin
                o_rf_addr = r_idx;
                w_next    = SAVE_WR;
            end
            SAVE_WR: begin
                o_rm_we   = 1'b1;
                o_rm_addr = w_rm_addr_full[AW-1:0];
                if (!i_rm_busywait) w_next = w_last ? FIN : SAVE_RD;
            end
            RST_RD: begin
                o_rm_re   = 1'b1;
                o_rm_addr = w_rm_addr_full[AW-1:0];
                if (!i_rm_busywait) w_next = RST_WR;
            end
            RST_WR: begin
                o_rf_we   = 1'b1;
                o_rf_addr = r_idx;
                w_next    = w_last ? FIN : RST_RD;
            end
            FIN: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // terminal check at 31 precedes the increment, so the index never wraps to x0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx      <= FIRST_REG;
            r_bank     <= '0;
            r_rm_wdata <= '0;
            r_rf_wdata <= '0;
        end else begin
            if (w_start) begin
                r_idx  <= FIRST_REG;
                r_bank <= i_bank_sel;
            end
            if (r_state == SAVE_RD) r_rm_wdata <= i_rf_rdata;
            if (w_rd_commit) r_rf_wdata <= i_rm_rdata;
            if ((w_save_commit || r_state == RST_WR) && !w_last) r_idx <= r_idx + 1'b1;
        end
    end

    assign o_rm_wdata = r_rm_wdata;
    assign o_rf_wdata = r_rf_wdata;

`ifdef REG_XFER_CHECKSUM_EN
    logic [31:0] r_chk, r_ref;
    logic r_err, r_is_save;
    // a save publishes its checksum as the reference; a restore compares against it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chk     <= '0;
            r_ref     <= '0;
            r_err     <= 1'b0;
            r_is_save <= 1'b0;
        end else begin
            if (w_start) begin
                r_chk     <= '0;
                r_is_save <= w_save_go;
            end else if (w_save_commit) begin
                r_chk <= r_chk ^ r_rm_wdata;
            end else if (w_rd_commit) begin
                r_chk <= r_chk ^ i_rm_rdata;
            end
            if (r_state == FIN) begin
                if (r_is_save)           r_ref <= r_chk;
                else if (r_chk != r_ref) r_err <= 1'b1;
            end
        end
    end
    assign o_err      = r_err;
    assign o_checksum = r_chk;
`endif
endmodule

// File: tb/tb_reg_bank_transfer_unit.sv
// tb_reg_bank_transfer_unit: scoreboard bench with RF/RM models and directed save/restore scenarios
module tb_reg_bank_transfer_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_save = 1'b0;
    logic start_restore = 1'b0;
    logic [1:0] bank_sel = 2'd0;
    logic [4:0] rf_addr;
    logic [31:0] rf_rdata, rf_wdata, rm_wdata, rm_rdata;
    logic [6:0] rm_addr;
    logic rf_we, rm_we, rm_re, bw, busy, done;
`ifdef REG_XFER_CHECKSUM_EN
    logic err;
    logic [31:0] chk;
    logic [31:0] exp_chk;
`endif
    logic [31:0] rf [32];
    logic [31:0] rm [128];
    logic bw_mode = 1'b0;
    int bw_cnt = 0;
    int checks = 0, failures = 0;
    int rm_wr_cnt = 0, rf_we_cnt = 0, re_cnt = 0, done_cnt = 0;
    logic [38:0] exp_rm [$];
    logic [36:0] exp_rf [$];
    logic [38:0] e_rm;
    logic [36:0] e_rf;
    int lat, cyc, w0, d0, r0, n;

    reg_bank_transfer_unit #(.BANKS(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_start_save(start_save), .i_start_restore(start_restore), .i_bank_sel(bank_sel),
        .o_rf_addr(rf_addr), .i_rf_rdata(rf_rdata), .o_rf_wdata(rf_wdata), .o_rf_we(rf_we),
        .o_rm_addr(rm_addr), .o_rm_wdata(rm_wdata), .i_rm_rdata(rm_rdata),
        .o_rm_we(rm_we), .o_rm_re(rm_re), .i_rm_busywait(bw),
        .o_busy(busy), .o_done(done)
`ifdef REG_XFER_CHECKSUM_EN
        , .o_err(err), .o_checksum(chk)
`endif
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_addr];
    assign rm_rdata = rm[rm_addr];
    // in stall mode every read sees exactly three busy cycles before completing
    assign bw = bw_mode && rm_re && (bw_cnt < 3);

    always @(posedge clk) bw_cnt <= rm_re ? ((bw_cnt < 3) ? bw_cnt + 1 : bw_cnt) : 0;

    always @(posedge clk) begin
        if (rm_we && !bw) rm[rm_addr] = rm_wdata;
        if (rf_we) rf[rf_addr] = rf_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rm_we || rm_re) check("we_re_exclusive", 64'(rm_we & rm_re), 64'd0);
            if (rm_we && !bw) begin
                rm_wr_cnt++;
                if (exp_rm.size() == 0) begin
                    failures++;
                    $display("FAIL rm_write_unexpected: got addr %0h data %0h expected none", rm_addr, rm_wdata);
                end else begin
                    e_rm = exp_rm.pop_front();
                    check("rm_write", {rm_addr, rm_wdata}, 64'(e_rm));
                end
            end
            if (rf_we) begin
                rf_we_cnt++;
                if (exp_rf.size() == 0) begin
                    failures++;
                    $display("FAIL rf_write_unexpected: got addr %0h data %0h expected none", rf_addr, rf_wdata);
                end else begin
                    e_rf = exp_rf.pop_front();
                    check("rf_write", {rf_addr, rf_wdata}, 64'(e_rf));
                end
            end
            if (rm_re) re_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic load_rf(input logic [31:0] base);
        rf[0] = 32'h0;
        for (int i = 1; i < 32; i++) rf[i] = base + 32'(i);
    endtask

    task automatic push_save(input logic [1:0] b, input logic [31:0] base);
        for (int i = 1; i < 32; i++) exp_rm.push_back({b, 5'(i), base + 32'(i)});
    endtask

    task automatic check_zero(input string name);
        check({name, ".rf_addr"}, 64'(rf_addr), 64'd0);
        check({name, ".rf_wdata"}, 64'(rf_wdata), 64'd0);
        check({name, ".rf_we"}, 64'(rf_we), 64'd0);
        check({name, ".rm_addr"}, 64'(rm_addr), 64'd0);
        check({name, ".rm_wdata"}, 64'(rm_wdata), 64'd0);
        check({name, ".rm_we"}, 64'(rm_we), 64'd0);
        check({name, ".rm_re"}, 64'(rm_re), 64'd0);
        check({name, ".busy"}, 64'(busy), 64'd0);
        check({name, ".done"}, 64'(done), 64'd0);
`ifdef REG_XFER_CHECKSUM_EN
        check({name, ".err"}, 64'(err), 64'd0);
        check({name, ".checksum"}, 64'(chk), 64'd0);
`endif
    endtask

    // called at the negedge where the start level was raised; cycle 1 is the first BUSY cycle
    task automatic run_xfer(output int l, output int c);
        l = 0;
        while (!busy && l < 20) begin
            @(negedge clk);
            l++;
        end
        bank_sel = bank_sel + 2'd1;
        c = 1;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        for (int i = 0; i < 128; i++) rm[i] = 32'h0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // save bank 2, RF[i]=A000_0000+i
        load_rf(32'hA000_0000);
        rm[7'h40] = 32'hDEAD_BEEF;
        bank_sel = 2'd2;
        push_save(2'd2, 32'hA000_0000);
        w0 = rm_wr_cnt;
        start_save = 1'b1;
        run_xfer(lat, cyc);
        check("save_start_latency", 64'(lat), 64'd2);
        check("save_done_cycle", 64'(cyc), 64'd63);
        @(negedge clk);
        #1;
        check("save_busy_after", 64'(busy), 64'd0);
        check("save_word_count", 64'(rm_wr_cnt - w0), 64'd31);
        check("save_rm40_untouched", 64'(rm[7'h40]), 64'hDEAD_BEEF);
        check("save_queue_empty", 64'(exp_rm.size()), 64'd0);
        start_save = 1'b0;

        // restore bank 1 preloaded with ~i, three stall cycles per read
        repeat (2) @(negedge clk);
        load_rf(32'h0);
        for (int i = 1; i < 32; i++) begin
            rm[{2'd1, 5'(i)}] = ~32'(i);
            exp_rf.push_back({5'(i), ~32'(i)});
        end
        bw_mode = 1'b1;
        bank_sel = 2'd1;
        w0 = rf_we_cnt;
        start_restore = 1'b1;
        run_xfer(lat, cyc);
        check("restore_start_latency", 64'(lat), 64'd2);
        check("restore_fin_cycle", 64'(cyc), 64'd156);
        @(negedge clk);
        #1;
        check("restore_rf_we_count", 64'(rf_we_cnt - w0), 64'd31);
        check("restore_queue_empty", 64'(exp_rf.size()), 64'd0);
        check("restore_rf5", 64'(rf[5]), 64'hFFFF_FFFA);
        check("restore_x0_untouched", 64'(rf[0]), 64'd0);
        bw_mode = 1'b0;
        start_restore = 1'b0;

        // simultaneous start edges: save wins
        repeat (2) @(negedge clk);
        load_rf(32'h5500_0000);
        bank_sel = 2'd3;
        push_save(2'd3, 32'h5500_0000);
        r0 = re_cnt;
        d0 = done_cnt;
        start_save = 1'b1;
        start_restore = 1'b1;
        run_xfer(lat, cyc);
        check("both_done_cycle", 64'(cyc), 64'd63);
        repeat (6) @(negedge clk);
        #1;
        check("both_no_rm_re", 64'(re_cnt - r0), 64'd0);
        check("both_one_done", 64'(done_cnt - d0), 64'd1);
        check("both_queue_empty", 64'(exp_rm.size()), 64'd0);
        start_save = 1'b0;
        start_restore = 1'b0;

        // save re-pulsed mid-transfer is ignored
        repeat (2) @(negedge clk);
        load_rf(32'h1234_0000);
        bank_sel = 2'd0;
        push_save(2'd0, 32'h1234_0000);
        d0 = done_cnt;
        start_save = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 20) start_save = 1'b0;
            if (c == 22) start_save = 1'b1;
            if (c == 24) start_save = 1'b0;
        end
        #1;
        check("repulse_one_done", 64'(done_cnt - d0), 64'd1);
        check("repulse_queue_empty", 64'(exp_rm.size()), 64'd0);
`ifdef REG_XFER_CHECKSUM_EN
        exp_chk = 32'h0;
        for (int i = 1; i < 32; i++) exp_chk = exp_chk ^ (32'h1234_0000 + 32'(i));
        check("save_checksum", 64'(chk), 64'(exp_chk));

        // clean restore of bank 0 matches the saved checksum
        bank_sel = 2'd0;
        for (int i = 1; i < 32; i++) exp_rf.push_back({5'(i), 32'h1234_0000 + 32'(i)});
        start_restore = 1'b1;
        run_xfer(lat, cyc);
        @(negedge clk);
        #1;
        check("clean_restore_err", 64'(err), 64'd0);
        start_restore = 1'b0;

        // corrupted word 5 flags a mismatch
        rm[{2'd0, 5'd5}] = rm[{2'd0, 5'd5}] ^ 32'h1;
        repeat (2) @(negedge clk);
        bank_sel = 2'd0;
        for (int i = 1; i < 32; i++) exp_rf.push_back({5'(i), (32'h1234_0000 + 32'(i)) ^ ((i == 5) ? 32'h1 : 32'h0)});
        start_restore = 1'b1;
        run_xfer(lat, cyc);
        @(negedge clk);
        #1;
        check("corrupt_restore_err", 64'(err), 64'd1);
        start_restore = 1'b0;
        repeat (2) @(negedge clk);
`endif

        // reset during word 10 of a save with start held high through reset
        load_rf(32'hC000_0000);
        bank_sel = 2'd2;
        push_save(2'd2, 32'hC000_0000);
        w0 = rm_wr_cnt;
        start_save = 1'b1;
        n = 0;
        while ((rm_wr_cnt - w0) < 10 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reset_reached_word10", 64'(rm_wr_cnt - w0), 64'd10);
        #1 rst_n = 1'b0;
        #1 check_zero("async_reset");
        exp_rm.delete();
        repeat (2) @(negedge clk);
        bank_sel = 2'd2;
        push_save(2'd2, 32'hC000_0000);
        w0 = rm_wr_cnt;
        rst_n = 1'b1;
        run_xfer(lat, cyc);
        check("post_reset_latency", 64'(lat), 64'd2);
        check("post_reset_done_cycle", 64'(cyc), 64'd63);
        @(negedge clk);
        #1;
        check("post_reset_word_count", 64'(rm_wr_cnt - w0), 64'd31);
        check("post_reset_queue_empty", 64'(exp_rm.size()), 64'd0);
        start_save = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
